// File: rtl/wr_burst_collector.sv
// Collects engine result words in a first-word-fall-through FIFO and hands them to the
// AXI write master as chunks of at most DEPTH words, one request per chunk.
module wr_burst_collector #(
   parameter int DATA_WIDTH = 512,
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = 64
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic                  job_start,
   input  logic [ADDR_WIDTH-1:0] job_dest_addr,
   input  logic [31:0]           job_words,
   output logic                  busy,
   output logic                  job_done,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   output logic                  wmst_start,
   output logic [ADDR_WIDTH-1:0] wmst_addr_offset,
   output logic [ADDR_WIDTH-1:0] wmst_xfer_size_in_bytes,
   input  logic                  wmst_done,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata
);
   localparam int PTR_W    = $clog2(DEPTH);
   localparam int CNT_W    = PTR_W + 1;
   localparam int WB_SHIFT = $clog2(DATA_WIDTH / 8);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   typedef enum logic [2:0] {IDLE, FILL, REQ, DRAIN, WAIT_DONE, FINISH} state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [CNT_W-1:0]      drained_q, drained_d;
   logic                  done_seen_q, done_seen_d;
   logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
   logic [31:0]           remaining_q, remaining_d;
   logic [31:0]           in_left_q, in_left_d;
   logic [ADDR_WIDTH-1:0] wm_addr_q, wm_addr_d;
   logic [ADDR_WIDTH-1:0] wm_size_q, wm_size_d;

   logic [CNT_W-1:0]      chunk;
   logic [ADDR_WIDTH-1:0] chunk_bytes;
   logic                  push;
   logic                  pop;

   // Chunk length is derived from remaining, which only moves when a chunk retires.
   always_comb begin
      chunk       = (remaining_q >= 32'(DEPTH)) ? DEPTH_C : remaining_q[CNT_W-1:0];
      chunk_bytes = ADDR_WIDTH'(chunk) << WB_SHIFT;
   end

   assign busy                    = (state_q != IDLE);
   assign job_done                = (state_q == FINISH);
   assign wmst_start              = (state_q == REQ);
   assign wmst_addr_offset        = wm_addr_q;
   assign wmst_xfer_size_in_bytes = wm_size_q;
   assign s_axis_tready           = busy && (count_q < DEPTH_C) && (in_left_q != 32'd0);
   assign m_axis_tvalid           = (state_q == DRAIN) && (count_q != '0) && (drained_q < chunk);
   assign m_axis_tdata            = mem_q[rd_ptr_q];
   assign push                    = s_axis_tvalid && s_axis_tready;
   assign pop                     = m_axis_tvalid && m_axis_tready;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = s_axis_tdata;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cur_addr_d  = cur_addr_q;
      remaining_d = remaining_q;
      in_left_d   = in_left_q;
      drained_d   = drained_q;
      done_seen_d = done_seen_q;
      wm_addr_d   = wm_addr_q;
      wm_size_d   = wm_size_q;
      if (push) begin
         in_left_d = in_left_q - 32'd1;
      end
      case (state_q)
         IDLE: begin
            if (job_start) begin
               cur_addr_d  = job_dest_addr;
               remaining_d = job_words;
               in_left_d   = job_words;
               state_d     = (job_words != 32'd0) ? FILL : FINISH;
            end
         end
         FILL: begin
            // Request parameters are captured here so they are valid with the start pulse.
            if (count_q >= chunk) begin
               wm_addr_d = cur_addr_q;
               wm_size_d = chunk_bytes;
               state_d   = REQ;
            end
         end
         REQ: begin
            drained_d   = '0;
            done_seen_d = 1'b0;
            state_d     = DRAIN;
         end
         DRAIN: begin
            if (wmst_done) begin
               done_seen_d = 1'b1;
            end
            if (pop) begin
               drained_d = drained_q + CNT_W'(1);
            end
            if (drained_d == chunk) begin
               state_d = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            // An early completion seen while draining counts as this chunk's done.
            if (wmst_done || done_seen_q) begin
               cur_addr_d  = cur_addr_q + chunk_bytes;
               remaining_d = remaining_q - 32'(chunk);
               state_d     = (remaining_q == 32'(chunk)) ? FINISH : FILL;
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         drained_q   <= '0;
         done_seen_q <= 1'b0;
         cur_addr_q  <= '0;
         remaining_q <= '0;
         in_left_q   <= '0;
         wm_addr_q   <= '0;
         wm_size_q   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         drained_q   <= drained_d;
         done_seen_q <= done_seen_d;
         cur_addr_q  <= cur_addr_d;
         remaining_q <= remaining_d;
         in_left_q   <= in_left_d;
         wm_addr_q   <= wm_addr_d;
         wm_size_q   <= wm_size_d;
         mem_q       <= mem_d;
      end
   end

endmodule

// File: tb/tb_wr_burst_collector.sv
// Randomized scoreboard bench for wr_burst_collector with a write-master responder model.
module tb_wr_burst_collector;
   localparam int DW    = 512;
   localparam int DEPTH = 16;
   localparam int AW    = 64;
   localparam int WB    = DW / 8;

   logic          ap_clk = 1'b0;
   logic          ap_rst_n;
   logic          job_start;
   logic [AW-1:0] job_dest_addr;
   logic [31:0]   job_words;
   logic          busy;
   logic          job_done;
   logic          s_axis_tvalid;
   logic          s_axis_tready;
   logic [DW-1:0] s_axis_tdata;
   logic          wmst_start;
   logic [AW-1:0] wmst_addr_offset;
   logic [AW-1:0] wmst_xfer_size_in_bytes;
   logic          wmst_done;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic [DW-1:0] m_axis_tdata;

   wr_burst_collector #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
      .ap_clk                  (ap_clk),
      .ap_rst_n                (ap_rst_n),
      .job_start               (job_start),
      .job_dest_addr           (job_dest_addr),
      .job_words               (job_words),
      .busy                    (busy),
      .job_done                (job_done),
      .s_axis_tvalid           (s_axis_tvalid),
      .s_axis_tready           (s_axis_tready),
      .s_axis_tdata            (s_axis_tdata),
      .wmst_start              (wmst_start),
      .wmst_addr_offset        (wmst_addr_offset),
      .wmst_xfer_size_in_bytes (wmst_xfer_size_in_bytes),
      .wmst_done               (wmst_done),
      .m_axis_tvalid           (m_axis_tvalid),
      .m_axis_tready           (m_axis_tready),
      .m_axis_tdata            (m_axis_tdata)
   );

   always #5 ap_clk = ~ap_clk;

   int n_chk = 0;
   int n_fail = 0;

   // Scoreboard state: expected requests and words, plus job-level bookkeeping.
   logic [AW-1:0] exp_req_addr [$];
   logic [AW-1:0] exp_req_size [$];
   logic [DW-1:0] exp_data [$];
   int            acc = 0;
   int            popped = 0;
   int            jw = 0;
   int            job_done_cnt = 0;
   int            cyc = 0;
   int            done_at = -10;
   int            rdy_mode = 0;
   bit            early_mode = 1'b0;
   bit            early_sent = 1'b0;
   bit            wm_active = 1'b0;
   int            wm_words = 0;
   int            wm_got = 0;
   bit            hold_act = 1'b0;
   logic [AW-1:0] hold_addr, hold_size;
   logic [AW-1:0] mon_ea, mon_es;
   bit            prev_mv = 1'b0;
   bit            prev_mr = 1'b0;
   bit            prev_ws = 1'b0;
   logic [DW-1:0] prev_md;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: event with nothing expected", name);
   endtask

   function automatic logic [DW-1:0] rand_word();
      logic [DW-1:0] w;
      for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   // Reference: a job is cut into DEPTH-word pieces at consecutive byte addresses.
   task automatic push_model(input logic [AW-1:0] addr, input int words);
      int            rem = words;
      logic [AW-1:0] a = addr;
      int            c;
      while (rem > 0) begin
         c = (rem > DEPTH) ? DEPTH : rem;
         exp_req_addr.push_back(a);
         exp_req_size.push_back(AW'(c * WB));
         a = a + AW'(c * WB);
         rem -= c;
      end
   endtask

   always @(posedge ap_clk) cyc <= cyc + 1;

   initial begin
      wmst_done = 1'b0;
      forever begin
         @(posedge ap_clk);
         #1;
         wmst_done = (cyc == done_at) && ap_rst_n;
      end
   end

   initial begin
      m_axis_tready = 1'b0;
      forever begin
         @(posedge ap_clk);
         #1;
         case (rdy_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = 1'($urandom_range(0, 1));
            default: m_axis_tready = 1'b0;
         endcase
      end
   end

   // Monitor: samples on the falling edge, pops expectations and plays the write master.
   always @(negedge ap_clk) begin
      if (ap_rst_n) begin
         chk("s_tready", DW'(s_axis_tready), DW'((acc < jw) && (acc - popped < DEPTH)));
         if (prev_mv && !prev_mr) begin
            chk("m_tvalid_hold", DW'(m_axis_tvalid), DW'(1));
            chk("m_tdata_hold", m_axis_tdata, prev_md);
         end
         if (hold_act && !wmst_start) begin
            chk("wmst_addr_hold", DW'(wmst_addr_offset), DW'(hold_addr));
            chk("wmst_size_hold", DW'(wmst_xfer_size_in_bytes), DW'(hold_size));
         end
         if (wmst_start) begin
            chk("wmst_start_pulse", DW'(prev_ws), DW'(0));
            if (exp_req_addr.size() == 0) begin
               fail_now("wmst_unexpected");
            end else begin
               mon_ea = exp_req_addr.pop_front();
               mon_es = exp_req_size.pop_front();
               chk("wmst_addr", DW'(wmst_addr_offset), DW'(mon_ea));
               chk("wmst_size", DW'(wmst_xfer_size_in_bytes), DW'(mon_es));
            end
            hold_act   = 1'b1;
            hold_addr  = wmst_addr_offset;
            hold_size  = wmst_xfer_size_in_bytes;
            wm_active  = 1'b1;
            wm_words   = int'(wmst_xfer_size_in_bytes / AW'(WB));
            wm_got     = 0;
            early_sent = 1'b0;
         end
         if (m_axis_tvalid && m_axis_tready) begin
            if (exp_data.size() == 0) fail_now("m_data_unexpected");
            else chk("m_data", m_axis_tdata, exp_data.pop_front());
            popped++;
            if (wm_active) begin
               wm_got++;
               if (wm_got == wm_words) begin
                  wm_active = 1'b0;
                  if (!early_sent) done_at = cyc + 1 + int'($urandom_range(0, 3));
               end else if (early_mode && !early_sent && wm_words >= 3 && wm_got == wm_words - 2) begin
                  done_at    = cyc + 1;
                  early_sent = 1'b1;
               end
            end
         end
         if (s_axis_tvalid && s_axis_tready) begin
            exp_data.push_back(s_axis_tdata);
            acc++;
         end
         if (job_done) job_done_cnt++;
         prev_mv = m_axis_tvalid;
         prev_mr = m_axis_tready;
         prev_md = m_axis_tdata;
         prev_ws = wmst_start;
      end
   end

   task automatic start_job(input logic [AW-1:0] addr, input int words);
      job_dest_addr = addr;
      job_words     = words;
      job_start     = 1'b1;
      tick();
      job_start = 1'b0;
      jw        = words;
      acc       = 0;
      popped    = 0;
   endtask

   task automatic send_words(input int n, input bit toggle);
      int            sent = 0;
      int            guard = 0;
      bit            ph = 1'b0;
      logic [DW-1:0] w;
      w = rand_word();
      while (sent < n && guard < 4000) begin
         s_axis_tdata  = w;
         s_axis_tvalid = toggle ? ph : 1'b1;
         ph = ~ph;
         @(negedge ap_clk);
         if (s_axis_tvalid && s_axis_tready) begin
            sent++;
            w = rand_word();
         end
         tick();
         guard++;
      end
      s_axis_tvalid = 1'b0;
      chk("send_complete", DW'(sent), DW'(n));
   endtask

   task automatic wait_done(input int base, input int budget, output int n);
      n = 0;
      while (job_done_cnt == base && n < budget) begin
         tick();
         n++;
      end
      chk("job_done_seen", DW'(job_done_cnt - base), DW'(1));
   endtask

   task automatic run_job(input logic [AW-1:0] addr, input int words, input bit toggle,
                          input int rmode, input bit early, input bit ign);
      int base;
      int n;
      rdy_mode   = rmode;
      early_mode = early;
      push_model(addr, words);
      base = job_done_cnt;
      start_job(addr, words);
      if (words == 0) begin
         chk("busy_empty_job", DW'(busy), DW'(1));
      end else begin
         chk("busy_after_start", DW'(busy), DW'(1));
      end
      if (ign) begin
         job_dest_addr = 64'h0DEA_D000;
         job_words     = 5;
         job_start     = 1'b1;
         tick();
         job_start = 1'b0;
         chk("busy_ignored_start", DW'(busy), DW'(1));
      end
      send_words(words, toggle);
      wait_done(base, 3000, n);
      if (words == 0) chk("empty_job_latency", DW'(n <= 3), DW'(1));
      chk("busy_after_done", DW'(busy), DW'(0));
      chk("job_done_one_cycle", DW'(job_done), DW'(0));
      chk("req_all_issued", DW'(exp_req_addr.size()), DW'(0));
      chk("data_all_out", DW'(exp_data.size()), DW'(0));
      chk("words_out", DW'(popped), DW'(words));
      early_mode = 1'b0;
   endtask

   task automatic check_zero(input string pfx);
      chk({pfx, "_busy"}, DW'(busy), DW'(0));
      chk({pfx, "_job_done"}, DW'(job_done), DW'(0));
      chk({pfx, "_s_tready"}, DW'(s_axis_tready), DW'(0));
      chk({pfx, "_wmst_start"}, DW'(wmst_start), DW'(0));
      chk({pfx, "_m_tvalid"}, DW'(m_axis_tvalid), DW'(0));
      chk({pfx, "_wmst_addr"}, DW'(wmst_addr_offset), DW'(0));
      chk({pfx, "_wmst_size"}, DW'(wmst_xfer_size_in_bytes), DW'(0));
      chk({pfx, "_m_tdata"}, m_axis_tdata, DW'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached before end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      ap_rst_n      = 1'b0;
      job_start     = 1'b0;
      job_dest_addr = '0;
      job_words     = '0;
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = '0;
      repeat (3) @(posedge ap_clk);
      #1;
      check_zero("reset");
      ap_rst_n = 1'b1;
      tick();
      check_zero("idle");

      run_job(64'h1000, 4, 1'b0, 0, 1'b0, 1'b0);
      run_job(64'h1000, 40, 1'b0, 0, 1'b0, 1'b0);
      run_job(64'h1000, 40, 1'b1, 1, 1'b0, 1'b0);
      run_job(64'h3000, 0, 1'b0, 0, 1'b0, 1'b0);
      run_job(64'h2000, 20, 1'b0, 0, 1'b1, 1'b1);
      for (int j = 0; j < 3; j++) begin
         run_job(AW'($urandom_range(0, 4095)) << 6, int'($urandom_range(1, 50)),
                 1'($urandom_range(0, 1)), 1, 1'b0, 1'b0);
      end

      // Abandon a job mid-drain: FIFO full, write master stalled.
      rdy_mode = 2;
      push_model(64'h5000, 40);
      start_job(64'h5000, 40);
      send_words(16, 1'b0);
      repeat (3) tick();
      chk("drain_tvalid_before_reset", DW'(m_axis_tvalid), DW'(1));
      #2;
      ap_rst_n = 1'b0;
      #1;
      check_zero("mid_reset");
      exp_req_addr.delete();
      exp_req_size.delete();
      exp_data.delete();
      jw        = 0;
      acc       = 0;
      popped    = 0;
      done_at   = -10;
      wm_active = 1'b0;
      hold_act  = 1'b0;
      prev_mv   = 1'b0;
      prev_mr   = 1'b0;
      prev_ws   = 1'b0;
      rdy_mode  = 0;
      repeat (2) tick();
      ap_rst_n = 1'b1;
      tick();
      check_zero("after_reset");
      run_job(64'h8000, 2, 1'b0, 0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
